// File: rtl/score_scan_if.sv
// Bundle between the game controller / display path and score_scan.
// The slave modport is the scoreboard side; the master modport is whoever drives points.
interface score_scan_if;
  logic       pointL;
  logic       pointR;
  logic       clr_score;
  logic [3:0] D;
  logic [3:0] an_n;
  logic       game_over;

  modport master (
    output pointL, pointR, clr_score,
    input  D, an_n, game_over
  );

  modport slave (
    input  pointL, pointR, clr_score,
    output D, an_n, game_over
  );
endinterface

// File: rtl/score_scan.sv
// Two-player BCD scoreboard with win-by-two detection, scanning four digits onto one shared bus.
// Build option SCORE_BLANK_LEAD_ZERO_EN darkens any tens digit whose value is zero.
module score_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int WIN_SCORE   = 11
) (
  input logic         clk,
  input logic         rst,
  score_scan_if.slave bus
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [7:0]       WIN_BIN  = 8'(WIN_SCORE);

  typedef enum logic [1:0] {
    SLOT_R_ONES = 2'd0,
    SLOT_R_TENS = 2'd1,
    SLOT_L_ONES = 2'd2,
    SLOT_L_TENS = 2'd3
  } slot_e;

  logic [7:0]       scoreL_q, scoreL_d;
  logic [7:0]       scoreR_q, scoreR_d;
  logic             gameOver_q, gameOver_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_e            idx_q, idx_d;
  logic [3:0]       digit_q, digit_d;
  logic [3:0]       anode_q, anode_d;
  logic             pointOk;
  logic             winL, winR;

  // Scores are {tens, ones}; 99 is the ceiling and simply holds.
  function automatic logic [7:0] bcdInc(input logic [7:0] s);
    if (s == 8'h99) begin
      return s;
    end
    if (s[3:0] == 4'd9) begin
      return {s[7:4] + 4'd1, 4'd0};
    end
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcdToBin(input logic [7:0] s);
    return ({4'd0, s[7:4]} * 8'd10) + {4'd0, s[3:0]};
  endfunction

  // Win is judged on the registered scores, so it lands one edge after the deciding point.
  always_comb begin
    winL = (bcdToBin(scoreL_q) >= WIN_BIN) &&
           (bcdToBin(scoreL_q) >= bcdToBin(scoreR_q) + 8'd2);
    winR = (bcdToBin(scoreR_q) >= WIN_BIN) &&
           (bcdToBin(scoreR_q) >= bcdToBin(scoreL_q) + 8'd2);
  end

  always_comb begin
    scoreL_d   = scoreL_q;
    scoreR_d   = scoreR_q;
    gameOver_d = gameOver_q | winL | winR;
    pointOk    = (bus.pointL ^ bus.pointR) && !gameOver_q;
    if (bus.clr_score) begin
      scoreL_d   = 8'h00;
      scoreR_d   = 8'h00;
      gameOver_d = 1'b0;
    end else if (pointOk) begin
      if (bus.pointL) begin
        scoreL_d = bcdInc(scoreL_q);
      end else begin
        scoreR_d = bcdInc(scoreR_q);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      unique case (idx_q)
        SLOT_R_ONES: idx_d = SLOT_R_TENS;
        SLOT_R_TENS: idx_d = SLOT_L_ONES;
        SLOT_L_ONES: idx_d = SLOT_L_TENS;
        SLOT_L_TENS: idx_d = SLOT_R_ONES;
        default:     idx_d = SLOT_R_ONES;
      endcase
    end
  end

  // Digit and anode are produced from the same registered slot so they can never skew.
  always_comb begin
    digit_d = 4'd0;
    anode_d = 4'b1111;
    unique case (idx_q)
      SLOT_R_ONES: begin digit_d = scoreR_q[3:0]; anode_d = 4'b1110; end
      SLOT_R_TENS: begin digit_d = scoreR_q[7:4]; anode_d = 4'b1101; end
      SLOT_L_ONES: begin digit_d = scoreL_q[3:0]; anode_d = 4'b1011; end
      SLOT_L_TENS: begin digit_d = scoreL_q[7:4]; anode_d = 4'b0111; end
      default:     begin digit_d = 4'd0;          anode_d = 4'b1111; end
    endcase
`ifdef SCORE_BLANK_LEAD_ZERO_EN
    if (((idx_q == SLOT_R_TENS) || (idx_q == SLOT_L_TENS)) && (digit_d == 4'd0)) begin
      anode_d = 4'b1111;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scoreL_q   <= 8'h00;
      scoreR_q   <= 8'h00;
      gameOver_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= SLOT_R_ONES;
      digit_q    <= 4'd0;
      anode_q    <= 4'b1110;
    end else begin
      scoreL_q   <= scoreL_d;
      scoreR_q   <= scoreR_d;
      gameOver_q <= gameOver_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      digit_q    <= digit_d;
      anode_q    <= anode_d;
    end
  end

  assign bus.D         = digit_q;
  assign bus.an_n      = anode_q;
  assign bus.game_over = gameOver_q;

endmodule

// File: tb/tb_score_scan.sv
// Self-checking bench for score_scan: two instances (win at 11 and at 99) against a score-level model.
// Honours SCORE_BLANK_LEAD_ZERO_EN in its expectations when the build defines it.
module tb_score_scan;

  localparam int DIV = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  score_scan_if ifA ();
  score_scan_if ifB ();

  score_scan #(.REFRESH_DIV(DIV), .WIN_SCORE(11)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  score_scan #(.REFRESH_DIV(DIV), .WIN_SCORE(99)) dutB (.clk(clk), .rst(rst), .bus(ifB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: plain integer scores, a win flag and a count of edges since reset.
  int         mL[2]       = '{0, 0};
  int         mR[2]       = '{0, 0};
  bit         mGo[2]      = '{0, 0};
  int         winScore[2] = '{11, 99};
  logic [3:0] expD[2]     = '{4'd0, 4'd0};
  logic [3:0] expAn[2]    = '{4'b1110, 4'b1110};
  logic       expGo[2]    = '{1'b0, 1'b0};
  int         tick        = 0;

  task automatic modelStep(input int k, input logic pl, input logic pr, input logic cl);
    int  slot;
    bit  win;
    if (rst) begin
      mL[k] = 0; mR[k] = 0; mGo[k] = 0;
      expD[k] = 4'd0; expAn[k] = 4'b1110; expGo[k] = 1'b0;
      return;
    end
    slot = (tick / DIV) % 4;
    case (slot)
      0: begin expD[k] = 4'(mR[k] % 10); expAn[k] = 4'b1110; end
      1: begin expD[k] = 4'(mR[k] / 10); expAn[k] = 4'b1101; end
      2: begin expD[k] = 4'(mL[k] % 10); expAn[k] = 4'b1011; end
      default: begin expD[k] = 4'(mL[k] / 10); expAn[k] = 4'b0111; end
    endcase
`ifdef SCORE_BLANK_LEAD_ZERO_EN
    if ((slot == 1 || slot == 3) && expD[k] == 4'd0) expAn[k] = 4'b1111;
`endif
    win = (mL[k] >= winScore[k] && mL[k] >= mR[k] + 2) ||
          (mR[k] >= winScore[k] && mR[k] >= mL[k] + 2);
    if (cl) begin
      mL[k] = 0; mR[k] = 0; mGo[k] = 0;
    end else begin
      if (!mGo[k] && (pl ^ pr)) begin
        if (pl) mL[k] = (mL[k] < 99) ? mL[k] + 1 : 99;
        else    mR[k] = (mR[k] < 99) ? mR[k] + 1 : 99;
      end
      mGo[k] = mGo[k] || win;
    end
    expGo[k] = mGo[k];
  endtask

  always @(posedge clk) begin
    modelStep(0, ifA.pointL, ifA.pointR, ifA.clr_score);
    modelStep(1, ifB.pointL, ifB.pointR, ifB.clr_score);
    if (rst) tick = 0;
    else     tick = tick + 1;
  end

  // Holds the given inputs for exactly one clock, starting from just after a falling edge.
  task automatic applyStimulus(input int k, input logic pl, input logic pr, input logic cl);
    if (k == 0) begin
      ifA.pointL = pl; ifA.pointR = pr; ifA.clr_score = cl;
    end else begin
      ifB.pointL = pl; ifB.pointR = pr; ifB.clr_score = cl;
    end
    @(negedge clk);
    ifA.pointL = 1'b0; ifA.pointR = 1'b0; ifA.clr_score = 1'b0;
    ifB.pointL = 1'b0; ifB.pointR = 1'b0; ifB.clr_score = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] wantAn;
    int         slot;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ifA.an_n !== 4'b1110 || ifA.D !== 4'd0 || ifA.game_over !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_values: an_n=%b D=%h go=%b expected an_n=1110 D=0 go=0",
               ifA.an_n, ifA.D, ifA.game_over);
    end
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      slot   = ((i - 1) / DIV) % 4;
      wantAn = ~(4'b0001 << slot);
`ifdef SCORE_BLANK_LEAD_ZERO_EN
      if (slot == 1 || slot == 3) wantAn = 4'b1111;
`endif
      checks++;
      if (ifA.an_n !== wantAn || ifA.D !== 4'd0) begin
        failures++;
        $display("[TB] FAIL scan_sequence cycle %0d: an_n=%b D=%h expected an_n=%b D=0",
                 i, ifA.an_n, ifA.D, wantAn);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ifA.an_n !== 4'b1110 || ifA.D !== 4'd0) begin
      failures++;
      $display("[TB] FAIL midframe_reset: an_n=%b D=%h expected an_n=1110 D=0", ifA.an_n, ifA.D);
    end
    rst = 1'b0;
  endtask

  task automatic test_bcd_carry();
    int seen;
    int badD;
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    repeat (9) begin
      applyStimulus(0, 1'b0, 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    seen = 0;
    repeat (4 * DIV) begin
      @(negedge clk);
      checks++;
      if (ifA.D !== expD[0] || ifA.an_n !== expAn[0] || ifA.game_over !== expGo[0]) begin
        failures++;
        $display("[TB] FAIL bcd9_frame: D=%h an_n=%b go=%b expected D=%h an_n=%b go=%b",
                 ifA.D, ifA.an_n, ifA.game_over, expD[0], expAn[0], expGo[0]);
      end
`ifdef SCORE_BLANK_LEAD_ZERO_EN
      if (ifA.an_n === 4'b1111) seen++;
`else
      if (ifA.an_n === 4'b1101) seen++;
`endif
    end
    checks++;
`ifdef SCORE_BLANK_LEAD_ZERO_EN
    if (seen !== 2 * DIV) begin
      failures++;
      $display("[TB] FAIL bcd9_blank: dark cycles=%0d expected %0d", seen, 2 * DIV);
    end
`else
    if (seen !== DIV) begin
      failures++;
      $display("[TB] FAIL bcd9_tens_lit: idx1 cycles=%0d expected %0d", seen, DIV);
    end
`endif
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    seen = 0;
    badD = 0;
    repeat (4 * DIV) begin
      @(negedge clk);
      checks++;
      if (ifA.D !== expD[0] || ifA.an_n !== expAn[0] || ifA.game_over !== expGo[0]) begin
        failures++;
        $display("[TB] FAIL bcd10_frame: D=%h an_n=%b go=%b expected D=%h an_n=%b go=%b",
                 ifA.D, ifA.an_n, ifA.game_over, expD[0], expAn[0], expGo[0]);
      end
      if (ifA.an_n === 4'b1101) begin
        seen++;
        if (ifA.D !== 4'd1) badD++;
      end
      if (ifA.an_n === 4'b1110 && ifA.D !== 4'd0) badD++;
    end
    checks++;
    if (seen !== DIV || badD !== 0) begin
      failures++;
      $display("[TB] FAIL bcd_carry_10: idx1 cycles=%0d bad digits=%0d expected %0d and 0",
               seen, badD, DIV);
    end
  endtask

  task automatic test_win_by_two();
    int badD;
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    repeat (10) begin
      applyStimulus(0, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (ifA.game_over !== 1'b0) begin
      failures++;
      $display("[TB] FAIL no_win_11_10: go=%b expected 0", ifA.game_over);
    end
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ifA.game_over !== 1'b0) begin
      failures++;
      $display("[TB] FAIL win_too_early: go=%b expected 0", ifA.game_over);
    end
    @(negedge clk);
    checks++;
    if (ifA.game_over !== 1'b1) begin
      failures++;
      $display("[TB] FAIL win_12_10: go=%b expected 1", ifA.game_over);
    end
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    badD = 0;
    repeat (4 * DIV) begin
      @(negedge clk);
      checks++;
      if (ifA.D !== expD[0] || ifA.an_n !== expAn[0] || ifA.game_over !== expGo[0]) begin
        failures++;
        $display("[TB] FAIL after_win_frame: D=%h an_n=%b go=%b expected D=%h an_n=%b go=%b",
                 ifA.D, ifA.an_n, ifA.game_over, expD[0], expAn[0], expGo[0]);
      end
      if (ifA.an_n === 4'b1110 && ifA.D !== 4'd0) badD++;
      if (ifA.an_n === 4'b1101 && ifA.D !== 4'd1) badD++;
      if (ifA.an_n === 4'b0111 && ifA.D !== 4'd1) badD++;
      if (ifA.an_n === 4'b1011 && ifA.D !== 4'd2) badD++;
    end
    checks++;
    if (badD !== 0) begin
      failures++;
      $display("[TB] FAIL point_after_win: bad digits=%0d expected 0 (score 12-10)", badD);
    end
  endtask

  task automatic test_clear_priority();
    int badD;
    checks++;
    if (ifA.game_over !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clear_precondition: go=%b expected 1", ifA.game_over);
    end
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ifA.game_over !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_go: go=%b expected 0", ifA.game_over);
    end
    @(negedge clk);
    badD = 0;
    repeat (4 * DIV) begin
      @(negedge clk);
      checks++;
      if (ifA.D !== expD[0] || ifA.an_n !== expAn[0] || ifA.game_over !== expGo[0]) begin
        failures++;
        $display("[TB] FAIL clear_frame: D=%h an_n=%b go=%b expected D=%h an_n=%b go=%b",
                 ifA.D, ifA.an_n, ifA.game_over, expD[0], expAn[0], expGo[0]);
      end
      if (ifA.D !== 4'd0) badD++;
    end
    checks++;
    if (badD !== 0) begin
      failures++;
      $display("[TB] FAIL clear_scores: nonzero digits=%0d expected 0", badD);
    end
  endtask

  task automatic test_simultaneous();
    int badD;
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(0, 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(0, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    badD = 0;
    repeat (4 * DIV) begin
      @(negedge clk);
      checks++;
      if (ifA.D !== expD[0] || ifA.an_n !== expAn[0] || ifA.game_over !== expGo[0]) begin
        failures++;
        $display("[TB] FAIL simul_frame: D=%h an_n=%b go=%b expected D=%h an_n=%b go=%b",
                 ifA.D, ifA.an_n, ifA.game_over, expD[0], expAn[0], expGo[0]);
      end
      if (ifA.an_n === 4'b1011 && ifA.D !== 4'd3) badD++;
      if (ifA.an_n === 4'b1110 && ifA.D !== 4'd2) badD++;
    end
    checks++;
    if (badD !== 0) begin
      failures++;
      $display("[TB] FAIL simultaneous_ignored: bad digits=%0d expected 0 (score 3-2)", badD);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      ifA.pointL    = (r < 45);
      ifA.pointR    = (r >= 40 && r < 72);
      ifA.clr_score = (r == 99);
      @(negedge clk);
      checks++;
      if (ifA.D !== expD[0] || ifA.an_n !== expAn[0] || ifA.game_over !== expGo[0]) begin
        failures++;
        $display("[TB] FAIL random_cycle %0d: D=%h an_n=%b go=%b expected D=%h an_n=%b go=%b",
                 i, ifA.D, ifA.an_n, ifA.game_over, expD[0], expAn[0], expGo[0]);
      end
    end
    ifA.pointL = 1'b0; ifA.pointR = 1'b0; ifA.clr_score = 1'b0;
  endtask

  task automatic test_saturation();
    int seen;
    int badD;
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    repeat (105) applyStimulus(1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ifB.game_over !== 1'b1) begin
      failures++;
      $display("[TB] FAIL saturate_go: go=%b expected 1", ifB.game_over);
    end
    seen = 0;
    badD = 0;
    repeat (4 * DIV) begin
      @(negedge clk);
      checks++;
      if (ifB.D !== expD[1] || ifB.an_n !== expAn[1] || ifB.game_over !== expGo[1]) begin
        failures++;
        $display("[TB] FAIL saturate_frame: D=%h an_n=%b go=%b expected D=%h an_n=%b go=%b",
                 ifB.D, ifB.an_n, ifB.game_over, expD[1], expAn[1], expGo[1]);
      end
      if (ifB.an_n === 4'b0111 || ifB.an_n === 4'b1011) begin
        seen++;
        if (ifB.D !== 4'd9) badD++;
      end
    end
    checks++;
    if (seen !== 2 * DIV || badD !== 0) begin
      failures++;
      $display("[TB] FAIL saturate_99: left cycles=%0d bad digits=%0d expected %0d and 0",
               seen, badD, 2 * DIV);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifA.pointL = 1'b0; ifA.pointR = 1'b0; ifA.clr_score = 1'b0;
    ifB.pointL = 1'b0; ifB.pointR = 1'b0; ifB.clr_score = 1'b0;
    @(negedge clk);
    test_reset();
    test_bcd_carry();
    test_win_by_two();
    test_clear_priority();
    test_simultaneous();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
